mem_burst_initiator: RTL and testbench

Initiator side of the byte-addressed, big-endian memory port. It accepts single-word or burst read/write requests from a client such as instruction fetch or the load/store stage. It sequences one memory beat per clock on `mem_address`/`mem_enable`/`mem_rw`/`mem_access_size` and streams the write data out and the read data back. It sits between the pipeline and the `memory` block and owns all address stepping and beat counting.

---
 rtl/mem_if_pkg.sv | 36 +++
 rtl/burst_addr_gen.sv | 53 +++++
 rtl/mem_burst_initiator.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_burst_initiator.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the big-endian, byte-addressed memory port:
//   - access-size encodings carried on mem_access_size / req_size
//   - size_to_words(): burst length in words for an access-size code
//   - state_e: burst initiator FSM states
//   - START_ADDR_DEF / DEPTH_DEF: default memory window
// -----------------------------------------------------------------------------
package mem_if_pkg;

  localparam logic [1:0] SIZE_1W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_16W = 2'b11;

  localparam logic [31:0] START_ADDR_DEF = 32'h8002_0000;
  localparam int unsigned DEPTH_DEF      = 1048576;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RD_LAST = 2'd3
  } state_e;

  // Burst length in words (1..16) for an access-size code.
  function automatic logic [4:0] size_to_words(input logic [1:0] size);
    case (size)
      SIZE_1W:  return 5'd1;
      SIZE_4W:  return 5'd4;
      SIZE_8W:  return 5'd8;
      SIZE_16W: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// -----------------------------------------------------------------------------
// burst_addr_gen
// Beat counter and address stepper for one burst.
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : restart at beat 0 (request accept)
//   advance        : a beat was issued this cycle
//   base           : word-aligned burst base address
//   last_cnt       : index of the final beat (words-1)
//   addr           : base + 4*cnt, byte address of the current beat
//   last_beat      : current beat is the final one
// -----------------------------------------------------------------------------
module burst_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        last_cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat
);

  logic [3:0] cnt_q, cnt_d;

  assign last_beat = (cnt_q == last_cnt);
  assign addr      = base + {{(ADDR_W-6){1'b0}}, cnt_q, 2'b00};

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      // Return to 0 after the final beat so the counter never wraps and is
      // already clean for the next burst.
      cnt_d = last_beat ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_burst_initiator.sv
// -----------------------------------------------------------------------------
// mem_burst_initiator
// Initiator side of the byte-addressed memory port. Accepts single-word or
// burst (4/8/16 word) read/write requests and issues one memory beat per
// clock, streaming write data out and registered read data back.
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   req_valid/ready/rw/addr/size   client request handshake (rw: 1 = read)
//   wr_valid/ready/data     write word stream (valid low stalls the burst)
//   rd_valid/rd_data        read word stream, no backpressure
//   done                    one-cycle pulse at burst completion
//   err                     one-cycle pulse when a request is out of range
//   mem_address/data_in/access_size/rw/enable   memory beat outputs
//   mem_busy, mem_data_out  memory inputs (read data has 1-cycle latency)
//   busy_err                sticky mem_busy mismatch flag (option only)
//
// Build option: MEM_INIT_BUSY_CHECK_EN - when defined, mem_busy is checked on
// every beat against the expected burst-in-progress value and busy_err is
// present. When undefined, mem_busy is ignored.
// -----------------------------------------------------------------------------
module mem_burst_initiator
  import mem_if_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = START_ADDR_DEF,
  parameter int unsigned        DEPTH      = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_INIT_BUSY_CHECK_EN
  ,
  output logic              busy_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          size_q, size_d;
  logic                rw_q, rw_d;
  logic [3:0]          words_m1_q, words_m1_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                accept;
  logic                range_bad;
  logic [ADDR_W-1:0]   req_base;
  logic [4:0]          req_words;
  logic [ADDR_W:0]     req_off, req_end;
  logic [ADDR_W-1:0]   beat_addr;
  logic                last_beat;

  // Low address bits are forced to 00; keep them explicitly unused.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = req_addr[1:0];

  assign accept    = req_valid && req_ready;
  assign req_base  = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_words = size_to_words(req_size);

  // Range check carried in ADDR_W+1 bits so base offset + burst bytes cannot
  // wrap. The offset is meaningless when base < START_ADDR, but that case is
  // rejected by the first term.
  assign req_off   = {1'b0, req_base} - {1'b0, START_ADDR};
  assign req_end   = req_off + {{(ADDR_W-6){1'b0}}, req_words, 2'b00};
  assign range_bad = (req_base < START_ADDR) || (req_end > DEPTH_X);

  burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (accept),
    .advance   (mem_enable),
    .base      (base_q),
    .last_cnt  (words_m1_q),
    .addr      (beat_addr),
    .last_beat (last_beat)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and burst context
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    rw_d       = rw_q;
    words_m1_d = words_m1_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            base_d     = req_base;
            size_d     = req_size;
            rw_d       = req_rw;
            words_m1_d = 4'(req_words - 5'd1);
            state_d    = req_rw ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wr_valid && last_beat) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (last_beat) state_d = ST_RD_LAST;
      end
      ST_RD_LAST: begin
        // Final read word arrives from memory this cycle; done is registered
        // so it lines up with the last rd_valid.
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready       = 1'b0;
    wr_ready        = 1'b0;
    mem_enable      = 1'b0;
    mem_rw          = 1'b0;
    mem_access_size = 2'b00;
    mem_address     = '0;
    mem_data_in     = '0;
    case (state_q)
      ST_IDLE: begin
        // No accept in the done cycle: the client sees done before reissuing.
        req_ready = !done_q;
      end
      ST_WRITE: begin
        wr_ready        = 1'b1;
        mem_enable      = wr_valid;
        mem_access_size = size_q;
        mem_address     = beat_addr;
        mem_data_in     = wr_data;
      end
      ST_READ: begin
        mem_enable      = 1'b1;
        mem_rw          = 1'b1;
        mem_access_size = size_q;
        mem_address     = beat_addr;
      end
      ST_RD_LAST: begin
        mem_rw          = 1'b1;
        mem_access_size = size_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read return: mem_data_out is valid the cycle after a read beat and is
  // registered once more before reaching the client.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_pend_d  = (state_q == ST_READ);
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? mem_data_out : rd_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      size_q     <= '0;
      rw_q       <= 1'b0;
      words_m1_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      base_q     <= base_d;
      size_q     <= size_d;
      rw_q       <= rw_d;
      words_m1_q <= words_m1_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef MEM_INIT_BUSY_CHECK_EN
  // Memory should report busy on every beat of a multi-word burst except the
  // last one.
  logic busy_exp, busy_mismatch;
  logic busy_err_q, busy_err_d;

  assign busy_exp      = (words_m1_q != 4'd0) && !last_beat;
  assign busy_mismatch = mem_enable && (mem_busy != busy_exp);

  always_comb begin
    busy_err_d = busy_err_q | busy_mismatch;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_err_q <= 1'b0;
    end else begin
      busy_err_q <= busy_err_d;
    end
  end

  assign busy_err = busy_err_q;

  a_mem_busy_match : assert property (@(posedge clock) disable iff (!reset_n)
    !busy_mismatch)
    else $error("mem_busy mismatch at beat address %h", mem_address);
`else
  logic unused_busy;
  assign unused_busy = mem_busy;
`endif

endmodule

// File: tb/tb_mem_burst_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_initiator
// Self-checking bench for mem_burst_initiator. A memory model answers beats;
// stimulus tasks push expected beats and read words to scoreboard queues, and
// a negedge monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_mem_burst_initiator;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out = '0;
`ifdef MEM_INIT_BUSY_CHECK_EN
  logic        busy_err;
`endif

  mem_burst_initiator dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .done            (done),
    .err             (err),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data_out    (mem_data_out)
`ifdef MEM_INIT_BUSY_CHECK_EN
    ,
    .busy_err        (busy_err)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int wcount(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model: 1 MiB of words, unwritten locations read as ~address.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_model [262144];

  function automatic logic [17:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - START;
    return off[19:2];
  endfunction

  initial begin
    for (int i = 0; i < 262144; i++) mem_model[i] = ~(START + 32'(i) * 4);
  end

  always @(posedge clock) begin
    if (mem_enable && mem_rw)  mem_data_out <= mem_model[widx(mem_address)];
    if (mem_enable && !mem_rw) mem_model[widx(mem_address)] <= mem_data_in;
  end

  // Burst-in-progress indication as a well-behaved memory would give it.
  logic       busy_kill = 1'b0;
  logic [4:0] m_words;
  logic [4:0] beat_idx;
  assign m_words  = 5'(wcount(mem_access_size));
  assign mem_busy = !busy_kill && (m_words > 5'd1) && (beat_idx < m_words - 5'd1);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)        beat_idx <= '0;
    else if (mem_enable) beat_idx <= (beat_idx == m_words - 5'd1) ? 5'd0 : beat_idx + 5'd1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] data;
    logic [1:0]  size;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : ~a;
  endfunction

  int    done_cnt = 0, done_cyc = 0;
  int    err_cnt = 0, err_cyc = 0;
  int    rd_cnt = 0, rd_first = 0, rd_last = 0;
  logic  done_prev = 1'b0;
  beat_t mon_b;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_enable) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 32'(mem_enable), 32'd0);
        end else begin
          mon_b = beat_q.pop_front();
          check("beat_addr", mem_address, mon_b.addr);
          check("beat_rw", 32'(mem_rw), 32'(mon_b.rw));
          check("beat_size", 32'(mem_access_size), 32'(mon_b.size));
          if (!mon_b.rw) check("beat_wdata", mem_data_in, mon_b.data);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("unexpected_rd", 32'(rd_valid), 32'd0);
        else                  check("rd_data", rd_data, rd_q.pop_front());
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("ready_at_done", 32'(req_ready), 32'd0);
        check("beats_left_at_done", 32'(beat_q.size()), 32'd0);
        check("rd_left_at_done", 32'(rd_q.size()), 32'd0);
      end
      if (done_prev) check("ready_after_done", 32'(req_ready), 32'd1);
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        check("ready_at_err", 32'(req_ready), 32'd1);
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                           input string tag, output int acc);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_size  = size;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_accept"}, 32'(req_ready), 32'd1);
    acc = cyc;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] d0, input int stall_at, input int stall_len,
                         input int exp_lat, input string tag);
    logic [31:0] base;
    logic [31:0] wd[16];
    int          words, acc, dc0, n;
    beat_t       b;
    base  = {addr[31:2], 2'b00};
    words = wcount(size);
    for (int i = 0; i < words; i++) begin
      wd[i]  = (i == 0) ? d0 : $urandom;
      b.addr = base + 32'(i) * 4;
      b.rw   = rw;
      b.data = rw ? 32'd0 : wd[i];
      b.size = size;
      beat_q.push_back(b);
      if (rw) rd_q.push_back(shadow_rd(b.addr));
      else    shadow[b.addr] = wd[i];
    end
    dc0 = done_cnt;
    drive_req(rw, addr, size, tag, acc);
    if (!rw) begin
      for (int i = 0; i < words; i++) begin
        wr_valid = 1'b1;
        wr_data  = wd[i];
        @(posedge clock);
        #1;
        if (i == stall_at) begin
          wr_valid = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            @(negedge clock);
            check({tag, "_stall_en"}, 32'(mem_enable), 32'd0);
            check({tag, "_stall_addr"}, mem_address, base + 32'(i + 1) * 4);
            @(posedge clock);
            #1;
          end
        end
      end
      wr_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == dc0 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, "_done"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, "_latency"}, 32'(done_cyc - acc), 32'(exp_lat));
    @(negedge clock);
    check({tag, "_idle_size"}, 32'(mem_access_size), 32'd0);
    check({tag, "_idle_rw"}, 32'(mem_rw), 32'd0);
  endtask

  task automatic run_reject(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                            input string tag);
    int acc, e0, d0, n;
    e0 = err_cnt;
    d0 = done_cnt;
    drive_req(rw, addr, size, tag, acc);
    n = 0;
    while (err_cnt == e0 && n < 10) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, "_err"}, 32'(err_cnt - e0), 32'd1);
    check({tag, "_err_latency"}, 32'(err_cyc - acc), 32'd1);
    repeat (4) @(negedge clock);
    check({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
    check({tag, "_single_err"}, 32'(err_cnt - e0), 32'd1);
  endtask

  initial begin
    int acc, dc0, sa, sl, words;
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] a;
    beat_t       b;

    // Reset values
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_size_rw", {29'd0, mem_access_size, mem_rw}, 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single write then single read back
    run_req(1'b0, START, 2'b00, 32'hDEAD_BEEF, -1, 0, 2, "wr1");
    run_req(1'b1, START, 2'b00, 32'd0, -1, 0, 3, "rd1");

    // 16-word read burst
    rd_cnt = 0;
    run_req(1'b1, START + 32'h40, 2'b11, 32'd0, -1, 0, 18, "rd16");
    check("rd16_count", 32'(rd_cnt), 32'd16);
    check("rd16_consecutive", 32'(rd_last - rd_first), 32'd15);
    check("rd16_done_with_last", 32'(done_cyc), 32'(rd_last));

    // Stalled 4-word write, then read it back
    run_req(1'b0, START + 32'h80, 2'b01, 32'h1234_5678, 1, 2, 7, "wr4_stall");
    run_req(1'b1, START + 32'h80, 2'b01, 32'd0, -1, 0, 6, "rd4");

    // Misaligned request is forced to a word boundary
    run_req(1'b1, START + 32'h43, 2'b00, 32'd0, -1, 0, 3, "rd_misaligned");

    // Range boundaries
    run_reject(1'b0, START + 32'd1048572, 2'b01, "rej_top");
    run_reject(1'b1, 32'h8001_FFFC, 2'b00, "rej_low");
    run_req(1'b0, START + 32'd1048572, 2'b00, 32'hCAFE_F00D, -1, 0, 2, "wr_top");
    run_req(1'b1, START + 32'd1048572, 2'b00, 32'd0, -1, 0, 3, "rd_top");

    // Random write/read-back pairs
    for (int k = 0; k < 4; k++) begin
      sz    = 2'($urandom_range(0, 3));
      words = wcount(sz);
      a     = START + 32'h200 + (32'($urandom_range(0, 63)) << 2);
      sa    = (words > 1) ? int'($urandom_range(0, words - 2)) : -1;
      sl    = (sa >= 0) ? int'($urandom_range(0, 2)) : 0;
      rw    = 1'b0;
      run_req(rw, a, sz, $urandom, sa, sl, words + 1 + sl, "rnd_wr");
      run_req(1'b1, a, sz, 32'd0, -1, 0, words + 2, "rnd_rd");
    end

    // Reset during beat 5 of an 8-word read
    a = START + 32'h100;
    for (int i = 0; i < 5; i++) begin
      b.addr = a + 32'(i) * 4;
      b.rw   = 1'b1;
      b.data = 32'd0;
      b.size = 2'b10;
      beat_q.push_back(b);
      if (i < 3) rd_q.push_back(shadow_rd(b.addr));
    end
    dc0 = done_cnt;
    drive_req(1'b1, a, 2'b10, "rst_mid", acc);
    repeat (4) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_enable", 32'(mem_enable), 32'd0);
    check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_beats_seen", 32'(beat_q.size()), 32'd0);
    check("rst_mid_rd_seen", 32'(rd_q.size()), 32'd0);
    beat_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clock);
    check("rst_mid_no_done", 32'(done_cnt - dc0), 32'd0);
    check("rst_mid_quiet", {30'd0, mem_enable, rd_valid}, 32'd0);

    // Normal operation after reset
    run_req(1'b1, START, 2'b00, 32'd0, -1, 0, 3, "rd_after_rst");

`ifdef MEM_INIT_BUSY_CHECK_EN
    check("busy_err_clean", 32'(busy_err), 32'd0);
    busy_kill = 1'b1;
    run_req(1'b0, START + 32'h300, 2'b01, 32'h0000_0001, -1, 0, 5, "busy");
    busy_kill = 1'b0;
    check("busy_err_set", 32'(busy_err), 32'd1);
    repeat (3) @(negedge clock);
    check("busy_err_sticky", 32'(busy_err), 32'd1);
    reset_n = 1'b0;
    #1;
    check("busy_err_reset", 32'(busy_err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
